// File: rtl/rx_gain_parser.sv
// rtl/rx_gain_parser.sv - UART 8N1 receiver feeding a comma-separated decimal gain line parser
// Gains are staged field by field and only committed together on a well-formed newline.
module rx_gain_parser #(
  parameter int CPB = 434,
  parameter int NUM_GAINS = 3,
  parameter int GAIN_W = 6,
  parameter int MAX_DIGITS = 3,
  parameter logic [NUM_GAINS*GAIN_W-1:0] GAIN_INIT = {6'd5, 6'd1, 6'd3}
) (
  input  logic                        clk_50m,
  input  logic                        rst,
  input  logic                        rx,
  output logic [NUM_GAINS*GAIN_W-1:0] gains,
  output logic                        gains_valid,
  output logic                        frame_err,
  output logic                        parse_err
);

  localparam int CW = $clog2(CPB);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int FW = (NUM_GAINS > 1) ? $clog2(NUM_GAINS) : 1;
  localparam int PW = GAIN_W + 4;
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [FW-1:0] FIDX_LAST = FW'(NUM_GAINS - 1);
  localparam logic [DW-1:0] DCNT_MAX  = DW'(MAX_DIGITS);
  localparam logic [PW-1:0] GAIN_MAX  = PW'((1 << GAIN_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state, state_nx;
  logic          rx_meta, rs;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          at_half, at_bit, byte_strobe, frame_hit;

  logic [GAIN_W-1:0] acc, acc_nx;
  logic [DW-1:0]     dcnt;
  logic [FW-1:0]     fidx;
  logic [GAIN_W-1:0] stage [NUM_GAINS];
  logic              discard;
  logic [PW-1:0]     prod;
  logic              is_digit, tok_digit, tok_comma, tok_commit, tok_err;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  assign at_half = (cnt == HALF_LAST);
  assign at_bit  = (cnt == BIT_LAST);

  always_ff @(posedge clk_50m) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!rs) state_nx = S_START;
      S_START: if (at_half) state_nx = rs ? S_IDLE : S_DATA;
      S_DATA:  if (at_bit && bitn == 3'd7) state_nx = S_STOP;
      S_STOP:  if (at_bit) state_nx = rs ? S_IDLE : S_BREAK;
      S_BREAK: if (rs) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_strobe = (state == S_STOP) && at_bit && rs;
    frame_hit   = (state == S_STOP) && at_bit && !rs;
  end

  // cnt restarts on every state change so each phase counts from its own origin
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      if (state != state_nx || state == S_IDLE || state == S_BREAK || at_bit) cnt <= '0;
      else cnt <= cnt + CW'(1);
      if (state == S_START) bitn <= '0;
      if (state == S_DATA && at_bit) begin
        shreg <= {rs, shreg[7:1]};
        bitn  <= bitn + 3'd1;
      end
    end
  end

  always_comb begin
    is_digit   = (shreg >= 8'h30) && (shreg <= 8'h39);
    prod       = PW'(acc) * PW'(10) + PW'(shreg[3:0]);
    acc_nx     = (prod > GAIN_MAX) ? '1 : prod[GAIN_W-1:0];
    tok_digit  = 1'b0;
    tok_comma  = 1'b0;
    tok_commit = 1'b0;
    tok_err    = 1'b0;
    if (is_digit) begin
      if (dcnt == DCNT_MAX) tok_err = 1'b1;
      else                  tok_digit = 1'b1;
    end else begin
      case (shreg)
        8'h2C: if (dcnt == '0 || fidx == FIDX_LAST) tok_err = 1'b1; else tok_comma = 1'b1;
        8'h0A: if (fidx == FIDX_LAST && dcnt != '0) tok_commit = 1'b1; else tok_err = 1'b1;
        8'h0D: ;
        default: tok_err = 1'b1;
      endcase
    end
  end

  // An error on the newline itself ends the line, so it must not leave discard set
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      gains       <= GAIN_INIT;
      gains_valid <= 1'b0;
      frame_err   <= 1'b0;
      parse_err   <= 1'b0;
      acc         <= '0;
      dcnt        <= '0;
      fidx        <= '0;
      discard     <= 1'b0;
      for (int i = 0; i < NUM_GAINS; i++) stage[i] <= '0;
    end else begin
      gains_valid <= 1'b0;
      parse_err   <= 1'b0;
      frame_err   <= frame_hit;
      if (frame_hit) begin
        discard <= 1'b1;
        acc     <= '0;
        dcnt    <= '0;
        fidx    <= '0;
      end else if (byte_strobe) begin
        if (discard) begin
          if (shreg == 8'h0A) discard <= 1'b0;
        end else if (tok_err) begin
          parse_err <= 1'b1;
          discard   <= (shreg != 8'h0A);
          acc       <= '0;
          dcnt      <= '0;
          fidx      <= '0;
        end else if (tok_digit) begin
          acc  <= acc_nx;
          dcnt <= dcnt + DW'(1);
        end else if (tok_comma) begin
          stage[fidx] <= acc;
          fidx        <= fidx + FW'(1);
          acc         <= '0;
          dcnt        <= '0;
        end else if (tok_commit) begin
          for (int i = 0; i < NUM_GAINS; i++)
            gains[i*GAIN_W +: GAIN_W] <= (i == NUM_GAINS - 1) ? acc : stage[i];
          gains_valid <= 1'b1;
          acc         <= '0;
          dcnt        <= '0;
          fidx        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_gain_parser.sv
// tb/tb_rx_gain_parser.sv - scoreboard bench for rx_gain_parser with a line-level reference model
// Lines are modelled as whole strings: split on commas, validate field count and widths, saturate.
module tb_rx_gain_parser;

  localparam int CPB = 16;
  localparam int NG  = 3;
  localparam int GW  = 6;
  localparam int MD  = 3;
  localparam int PW  = NG * GW;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;
  localparam logic [PW-1:0] INIT = {6'd5, 6'd1, 6'd3};

  logic          clk_50m = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic [PW-1:0] gains;
  logic          gains_valid, frame_err, parse_err;

  rx_gain_parser #(.CPB(CPB), .NUM_GAINS(NG), .GAIN_W(GW), .MAX_DIGITS(MD), .GAIN_INIT(INIT)) dut (
    .clk_50m(clk_50m), .rst(rst), .rx(rx), .gains(gains),
    .gains_valid(gains_valid), .frame_err(frame_err), .parse_err(parse_err)
  );

  always #10 clk_50m = ~clk_50m;

  int total = 0, bad = 0, cyc = 0;
  int obs_perr = 0, obs_ferr = 0, exp_perr = 0, exp_ferr = 0;
  logic [PW-1:0] exp_q[$];
  int            cyc_q[$];
  logic [PW-1:0] cur_gains;
  logic [7:0]    line_q[$];
  bit            prev_gv = 1'b0;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  always @(negedge clk_50m) begin
    if (!rst) begin
      if (gains_valid) begin
        check("gains_valid single cycle", longint'(prev_gv), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected gains_valid: got pulse at cycle %0d want none", cyc);
        end else begin
          check("commit gains", longint'(gains), longint'(exp_q.pop_front()));
          check("commit latency", longint'(cyc), longint'(cyc_q.pop_front()));
        end
      end
      if (parse_err) obs_perr++;
      if (frame_err) obs_ferr++;
      if (parse_err || frame_err) check("err overlap", longint'(parse_err && frame_err), 0);
      prev_gv = gains_valid;
    end
  end

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic bit model_line(output logic [PW-1:0] g);
    int  vals[$];
    int  nds[$];
    int  cur = 0, nd = 0;
    bit  ok = 1'b1;
    logic [7:0] c;
    g = '0;
    for (int i = 0; i < line_q.size() - 1; i++) begin
      c = line_q[i];
      if (c == 8'h0D) continue;
      if (c >= 8'h30 && c <= 8'h39) begin
        cur = cur * 10 + int'(c) - 48;
        if (cur > 100000) cur = 100000;
        nd++;
      end else if (c == 8'h2C) begin
        vals.push_back(cur);
        nds.push_back(nd);
        cur = 0;
        nd = 0;
      end else ok = 1'b0;
    end
    vals.push_back(cur);
    nds.push_back(nd);
    if (vals.size() != NG) ok = 1'b0;
    foreach (nds[k]) if (nds[k] < 1 || nds[k] > MD) ok = 1'b0;
    if (ok)
      for (int k = 0; k < NG; k++)
        g[k*GW +: GW] = (vals[k] > (1 << GW) - 1) ? GW'((1 << GW) - 1) : GW'(vals[k]);
    return ok;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit push, input logic [PW-1:0] g);
    @(posedge clk_50m); #1;
    rx = 1'b0;
    if (push) begin
      exp_q.push_back(g);
      cyc_q.push_back(cyc + LAT);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk_50m); #1;
      rx = b[i];
    end
    repeat (CPB) @(posedge clk_50m); #1;
    rx = stop_ok;
    repeat (CPB) @(posedge clk_50m); #1;
    if (!stop_ok) begin
      repeat (2 * CPB) @(posedge clk_50m); #1;
    end
    rx = 1'b1;
    repeat ($urandom_range(1, 4)) @(posedge clk_50m);
  endtask

  task automatic load(input string s);
    line_q.delete();
    for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
  endtask

  task automatic line_checks(input string name);
    repeat (4) @(posedge clk_50m); #1;
    check({name, " parse_err count"}, obs_perr, exp_perr);
    check({name, " frame_err count"}, obs_ferr, exp_ferr);
    check({name, " held gains"}, longint'(gains), longint'(cur_gains));
  endtask

  task automatic run_line(input string name);
    logic [PW-1:0] g;
    bit ok;
    ok = model_line(g);
    for (int i = 0; i < line_q.size(); i++)
      send_byte(line_q[i], 1'b1, ok && (i == line_q.size() - 1), g);
    if (ok) cur_gains = g;
    else    exp_perr++;
    line_checks(name);
  endtask

  task automatic send_raw();
    for (int i = 0; i < line_q.size(); i++) send_byte(line_q[i], 1'b1, 1'b0, '0);
  endtask

  initial begin
    int nf, nd;
    cur_gains = INIT;
    repeat (4) @(posedge clk_50m); #1;
    check("reset gains", longint'(gains), longint'(INIT));
    check("reset gains_valid", longint'(gains_valid), 0);
    check("reset parse_err", longint'(parse_err), 0);
    check("reset frame_err", longint'(frame_err), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk_50m);

    load("12,4,60\n");   run_line("basic");
    check("basic value", longint'(gains), longint'({6'd60, 6'd4, 6'd12}));
    load("99,1,2\n");    run_line("saturate");
    check("saturate value", longint'(gains), longint'({6'd2, 6'd1, 6'd63}));
    load("1234,1,1\n");  run_line("too many digits");
    load("7,,3\n");      run_line("empty field");
    load("8,9\n");       run_line("short line");
    load("1,2,3\r\n");   run_line("crlf");
    check("crlf value", longint'(gains), longint'({6'd3, 6'd2, 6'd1}));

    send_byte(8'h35, 1'b0, 1'b0, '0);
    exp_ferr++;
    load(",2,3\n");
    send_raw();
    line_checks("frame error discard");
    load("4,5,6\n");     run_line("after frame error");

    @(posedge clk_50m); #1;
    rx = 1'b0;
    repeat (CPB * 3 / 10) @(posedge clk_50m); #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk_50m);
    line_checks("glitch");
    load("5,6,7\n");     run_line("after glitch");

    load("10,2");
    send_raw();
    @(posedge clk_50m); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk_50m); #1;
    check("mid-line reset gains", longint'(gains), longint'(INIT));
    rst = 1'b0;
    cur_gains = INIT;
    repeat (4) @(posedge clk_50m);
    load("1,1,1\n");     run_line("after reset");
    check("after reset value", longint'(gains), longint'({6'd1, 6'd1, 6'd1}));

    for (int n = 0; n < 15; n++) begin
      line_q.delete();
      nf = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 2 : 4) : 3;
      for (int f = 0; f < nf; f++) begin
        if (f > 0) line_q.push_back(8'h2C);
        nd = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : 4) : int'($urandom_range(1, 3));
        for (int d = 0; d < nd; d++) line_q.push_back(8'($urandom_range(48, 57)));
      end
      if ($urandom_range(0, 9) == 0) line_q.insert($urandom_range(0, line_q.size()), 8'h41);
      if ($urandom_range(0, 3) == 0) line_q.push_back(8'h0D);
      line_q.push_back(8'h0A);
      run_line("random");
    end

    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
